// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns 16-bit instruction fetches, data reads and data writes
// into one or two transfers on an 8-bit external byte bus.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   ifetch, pc                 instruction fetch request and halfword address
//   rstrobe, wmask             per-byte data read / write requests
//   addr, wdata, io_access     halfword data address, write data, I/O space flag
//   idone, rdone, wdone        one-cycle completion pulses
//   instr, rdata               fetched instruction / read data
//   bus_err                    flags a timed-out access alongside its done pulse
//   bus_req, bus_we, bus_io,
//   bus_addr, bus_wdata        byte-bus strobes driven by the controller
//   bus_rdata, bus_ack         byte-bus response
//
// State | meaning
// IDLE  | waiting for a request; the highest-priority one is latched here
// LO    | low byte ({a,0}) on the bus
// HI    | high byte ({a,1}) on the bus; first cycle is a gap after LO
// DONE  | one-cycle done pulse (plus bus_err after a timeout)
module mem_bus_ctrl #(
  parameter int VA      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifetch,
  input  logic [VA-2:0] pc,
  input  logic [1:0]    rstrobe,
  input  logic [1:0]    wmask,
  input  logic [VA-2:0] addr,
  input  logic [15:0]   wdata,
  input  logic          io_access,
  output logic          idone,
  output logic          rdone,
  output logic          wdone,
  output logic [15:0]   instr,
  output logic [15:0]   rdata,
  output logic          bus_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic          bus_io,
  output logic [VA-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  input  logic [7:0]    bus_rdata,
  input  logic          bus_ack
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_t;

  state_t        state, state_n;
  op_t           op_q, op_n;
  logic [1:0]    mask_q, mask_n;
  logic [VA-2:0] a_q;
  logic [15:0]   wd_q;
  logic          io_q;
  logic          gap_q;
  logic [7:0]    cnt_q;
  logic [15:0]   data_q;
  logic [15:0]   instr_q;
  logic          err_q;

  logic accept, req_on, ack_ok, timed_out;

  // Request priority: write > read > fetch; a fetch always moves both bytes.
  always_comb begin
    op_n   = OP_FETCH;
    mask_n = 2'b11;
    if (wmask != 2'b00) begin
      op_n   = OP_WRITE;
      mask_n = wmask;
    end else if (rstrobe != 2'b00) begin
      op_n   = OP_READ;
      mask_n = rstrobe;
    end
  end

  assign accept    = (state == IDLE) && ((wmask != 2'b00) || (rstrobe != 2'b00) || ifetch);
  // gap_q holds bus_req low for one cycle between the two bytes.
  assign req_on    = (state == LO) || ((state == HI) && !gap_q);
  assign ack_ok    = req_on && bus_ack;
  assign timed_out = req_on && !bus_ack && (cnt_q == WAIT_LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = mask_n[0] ? LO : HI;
      LO: begin
        if (ack_ok)         state_n = mask_q[1] ? HI : DONE;
        else if (timed_out) state_n = DONE;
      end
      HI:      if (ack_ok || timed_out) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= OP_FETCH;
      mask_q  <= 2'b00;
      a_q     <= '0;
      wd_q    <= 16'h0000;
      io_q    <= 1'b0;
      gap_q   <= 1'b0;
      cnt_q   <= 8'h00;
      data_q  <= 16'h0000;
      instr_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          op_q   <= op_n;
          mask_q <= mask_n;
          a_q    <= (op_n == OP_FETCH) ? pc : addr;
          wd_q   <= wdata;
          io_q   <= (op_n == OP_FETCH) ? 1'b0 : io_access;
          gap_q  <= 1'b0;
          cnt_q  <= 8'h00;
          data_q <= 16'h0000;
          err_q  <= 1'b0;
        end
        LO: begin
          if (ack_ok) begin
            data_q[7:0] <= bus_rdata;
            cnt_q       <= 8'h00;
            gap_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (timed_out) err_q <= 1'b1;
          end
        end
        HI: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (ack_ok) begin
            // A lone odd byte is returned right-justified.
            if (mask_q[0]) data_q[15:8] <= bus_rdata;
            else           data_q[7:0]  <= bus_rdata;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (timed_out) err_q <= 1'b1;
          end
        end
        DONE: if (op_q == OP_FETCH) instr_q <= data_q;
        default: ;
      endcase
    end
  end

  assign bus_req   = req_on;
  assign bus_addr  = req_on ? {a_q, (state == HI)} : '0;
  assign bus_we    = req_on && (op_q == OP_WRITE);
  assign bus_io    = req_on && io_q;
  assign bus_wdata = bus_we ? ((state == HI) ? wd_q[15:8] : wd_q[7:0]) : 8'h00;

  assign idone   = (state == DONE) && (op_q == OP_FETCH);
  assign rdone   = (state == DONE) && (op_q == OP_READ);
  assign wdone   = (state == DONE) && (op_q == OP_WRITE);
  assign bus_err = (state == DONE) && err_q;
  assign rdata   = data_q;
  assign instr   = idone ? data_q : instr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (TIMEOUT=4) with a small byte-bus responder.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ifetch = 1'b0;
  logic [14:0] pc = '0;
  logic [1:0]  rstrobe = 2'b00;
  logic [1:0]  wmask = 2'b00;
  logic [14:0] addr = '0;
  logic [15:0] wdata = 16'h0000;
  logic        io_access = 1'b0;
  logic        idone, rdone, wdone, bus_err, bus_req, bus_we, bus_io;
  logic [15:0] instr, rdata, bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_ack = 1'b0;

  mem_bus_ctrl #(.VA(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ifetch(ifetch), .pc(pc), .rstrobe(rstrobe),
    .wmask(wmask), .addr(addr), .wdata(wdata), .io_access(io_access),
    .idone(idone), .rdone(rdone), .wdone(wdone), .instr(instr), .rdata(rdata),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // responder configuration and logs
  int          ack_delay = 0;
  logic        ack_en = 1'b1;
  logic        spurious = 1'b0;
  logic [7:0]  byte_lo = 8'h00;
  logic [7:0]  byte_hi = 8'h00;
  int          wait_cnt = 0;
  logic        last_acked = 1'b0;
  int          gap_viol = 0;
  int          io_bad = 0;
  logic [15:0] log_addr[$];
  logic [7:0]  log_wdata[$];
  logic        log_we[$];

  task automatic clear_log();
    log_addr.delete();
    log_wdata.delete();
    log_we.delete();
    gap_viol = 0;
    io_bad = 0;
  endtask

  // Advance one cycle, then act as the byte-bus target for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_req && last_acked) gap_viol++;
    if (bus_req && !bus_io) io_bad++;
    if (bus_req) begin
      if (ack_en && wait_cnt == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = bus_addr[0] ? byte_hi : byte_lo;
        log_addr.push_back(bus_addr);
        log_wdata.push_back(bus_wdata);
        log_we.push_back(bus_we);
        wait_cnt  = 0;
      end else begin
        bus_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus_ack   = spurious;
      bus_rdata = spurious ? 8'h5A : 8'h00;
      wait_cnt  = 0;
    end
    last_acked = bus_req && bus_ack;
  endtask

  task automatic wait_done(input int max, output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < max) begin
      tick();
      lat++;
      if (idone || rdone || wdone) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({idone, rdone, wdone, bus_err, bus_req, bus_we, bus_io} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 0000000", {idone, rdone, wdone, bus_err, bus_req, bus_we, bus_io});
    end
    checks++;
    if ({bus_addr, bus_wdata, instr, rdata} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {bus_addr, bus_wdata, instr, rdata});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_req got %b exp 0", bus_req);
    end
  endtask

  task automatic test_fetch();
    int lat;
    logic got;
    clear_log();
    spurious = 1'b1;
    ack_delay = 0;
    byte_lo = 8'h34;
    byte_hi = 8'h12;
    pc = 15'h0010;
    ifetch = 1'b1;
    wait_done(20, lat, got);
    ifetch = 1'b0;
    checks++;
    if (got !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL fetch_latency got %0d (done=%b) exp 4", lat, got);
    end
    checks++;
    if ({idone, rdone, wdone, bus_err} !== 4'b1000) begin
      errors++;
      $display("FAIL fetch_pulses got %b exp 1000", {idone, rdone, wdone, bus_err});
    end
    checks++;
    if (instr !== 16'h1234) begin
      errors++;
      $display("FAIL fetch_instr got %h exp 1234", instr);
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h0020 || log_addr[1] !== 16'h0021 || log_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_addrs got n=%0d %h %h exp 0020 0021", log_addr.size(), log_addr.size() > 0 ? log_addr[0] : 16'hxxxx, log_addr.size() > 1 ? log_addr[1] : 16'hxxxx);
    end
    checks++;
    if (gap_viol != 0) begin
      errors++;
      $display("FAIL fetch_gap got %0d back-to-back req cycles exp 0", gap_viol);
    end
    spurious = 1'b0;
    tick();
    checks++;
    if (idone !== 1'b0 || instr !== 16'h1234 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold got idone=%b instr=%h req=%b exp 0 1234 0", idone, instr, bus_req);
    end
  endtask

  task automatic test_byte_write();
    int lat;
    logic got;
    clear_log();
    wmask = 2'b10;
    addr = 15'h0008;
    wdata = 16'hAB00;
    wait_done(20, lat, got);
    wmask = 2'b00;
    checks++;
    if (got !== 1'b1 || lat != 2 || {idone, rdone, wdone} !== 3'b001) begin
      errors++;
      $display("FAIL bwrite_done got lat=%0d pulses=%b exp 2 001", lat, {idone, rdone, wdone});
    end
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 16'h0011 || log_we[0] !== 1'b1 || log_wdata[0] !== 8'hAB) begin
      errors++;
      $display("FAIL bwrite_xfer got n=%0d addr=%h exp 1 0011 we=1 wdata=ab", log_addr.size(), log_addr.size() > 0 ? log_addr[0] : 16'hxxxx);
    end
    tick();
  endtask

  task automatic test_priority();
    int lat;
    logic got;
    clear_log();
    byte_lo = 8'h78;
    byte_hi = 8'h56;
    pc = 15'h0040;
    addr = 15'h0100;
    wdata = 16'hBEEF;
    wmask = 2'b11;
    ifetch = 1'b1;
    wait_done(20, lat, got);
    wmask = 2'b00;
    checks++;
    if (got !== 1'b1 || {idone, rdone, wdone} !== 3'b001) begin
      errors++;
      $display("FAIL prio_first got pulses=%b exp 001", {idone, rdone, wdone});
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h0200 || log_addr[1] !== 16'h0201 ||
        log_wdata[0] !== 8'hEF || log_wdata[1] !== 8'hBE || log_we[1] !== 1'b1) begin
      errors++;
      $display("FAIL prio_write_xfers got n=%0d exp 0200/ef 0201/be", log_addr.size());
    end
    clear_log();
    wait_done(20, lat, got);
    ifetch = 1'b0;
    checks++;
    if (got !== 1'b1 || lat != 5 || idone !== 1'b1 || instr !== 16'h5678) begin
      errors++;
      $display("FAIL prio_fetch got lat=%0d idone=%b instr=%h exp 5 1 5678", lat, idone, instr);
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h0080 || log_addr[1] !== 16'h0081 || log_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL prio_fetch_addrs got n=%0d exp 0080 0081", log_addr.size());
    end
    tick();
  endtask

  task automatic test_io_read();
    int lat;
    logic got;
    clear_log();
    ack_delay = 3;
    byte_lo = 8'hFF;
    byte_hi = 8'hEE;
    addr = 15'h0123;
    io_access = 1'b1;
    rstrobe = 2'b01;
    wait_done(20, lat, got);
    rstrobe = 2'b00;
    io_access = 1'b0;
    checks++;
    if (got !== 1'b1 || lat != 5 || {idone, rdone, wdone, bus_err} !== 4'b0100) begin
      errors++;
      $display("FAIL io_done got lat=%0d pulses=%b exp 5 0100", lat, {idone, rdone, wdone, bus_err});
    end
    checks++;
    if (rdata !== 16'h00FF) begin
      errors++;
      $display("FAIL io_rdata got %h exp 00ff", rdata);
    end
    checks++;
    if (io_bad != 0 || log_addr.size() != 1 || log_addr[0] !== 16'h0246) begin
      errors++;
      $display("FAIL io_bus got io_low=%0d n=%0d exp 0 1 (addr 0246)", io_bad, log_addr.size());
    end
    ack_delay = 0;
    tick();
  endtask

  task automatic test_timeout();
    int lat;
    logic got;
    clear_log();
    ack_en = 1'b0;
    addr = 15'h0050;
    rstrobe = 2'b11;
    wait_done(20, lat, got);
    rstrobe = 2'b00;
    checks++;
    if (got !== 1'b1 || lat != 5) begin
      errors++;
      $display("FAIL timeout_latency got %0d (done=%b) exp 5", lat, got);
    end
    checks++;
    if ({rdone, bus_err} !== 2'b11 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL timeout_result got rdone=%b err=%b rdata=%h exp 1 1 0000", rdone, bus_err, rdata);
    end
    ack_en = 1'b1;
    tick();
    checks++;
    if (bus_err !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after got err=%b req=%b exp 0 0", bus_err, bus_req);
    end
  endtask

  task automatic test_read_hi_byte();
    int lat;
    logic got;
    clear_log();
    byte_lo = 8'h11;
    byte_hi = 8'hC3;
    addr = 15'h0030;
    rstrobe = 2'b10;
    wait_done(20, lat, got);
    rstrobe = 2'b00;
    checks++;
    if (got !== 1'b1 || lat != 2 || rdone !== 1'b1 || rdata !== 16'h00C3) begin
      errors++;
      $display("FAIL rd_hi got lat=%0d rdone=%b rdata=%h exp 2 1 00c3", lat, rdone, rdata);
    end
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 16'h0061) begin
      errors++;
      $display("FAIL rd_hi_addr got n=%0d exp 1 (0061)", log_addr.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    logic got;
    logic seen_done;
    clear_log();
    ack_delay = 2;
    pc = 15'h0005;
    ifetch = 1'b1;
    n = 0;
    seen_done = 1'b0;
    tick();
    while (!(bus_req && bus_addr[0]) && n < 20) begin
      tick();
      if (idone) seen_done = 1'b1;
      n++;
    end
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 16'h000B || seen_done) begin
      errors++;
      $display("FAIL rmid_reach_hi got req=%b addr=%h exp 1 000b", bus_req, bus_addr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus_req, idone, rdone, wdone, bus_err} !== 5'b0 || instr !== 16'h0000 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rmid_cleared got req=%b dones=%b instr=%h rdata=%h exp all 0", bus_req, {idone, rdone, wdone, bus_err}, instr, rdata);
    end
    clear_log();
    ack_delay = 0;
    byte_lo = 8'h9A;
    byte_hi = 8'hBC;
    pc = 15'h0007;
    reset = 1'b1;
    wait_done(20, lat, got);
    ifetch = 1'b0;
    checks++;
    if (got !== 1'b1 || lat != 4 || idone !== 1'b1 || instr !== 16'hBC9A) begin
      errors++;
      $display("FAIL rmid_refetch got lat=%0d idone=%b instr=%h exp 4 1 bc9a", lat, idone, instr);
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h000E || log_addr[1] !== 16'h000F) begin
      errors++;
      $display("FAIL rmid_refetch_addrs got n=%0d exp 000e 000f", log_addr.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_write();
    test_priority();
    test_io_read();
    test_timeout();
    test_read_hi_byte();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
